// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative signed/unsigned multiply/divide unit with HI/LO registers
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic               op_r, sgn_r, neg_res, neg_rem, dz_r;
    logic [WIDTH-1:0]   a_r, b_r, a_raw;
    logic [2*WIDTH-1:0] acc;
    logic               fix_commit;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start_i && !cancel_i) state_next = S_PREP;
            S_PREP: state_next = S_RUN;
            S_RUN:  if (cnt == CNT_LAST) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // A flush aborts whatever is in flight, including the write-back cycle.
        if (cancel_i && state != S_IDLE) state_next = S_IDLE;
    end

    always_comb begin
        busy_o     = (state != S_IDLE);
        fix_commit = (state == S_FIX) && !cancel_i;
    end

    always_comb begin
        a_abs = (sgn_r && a_r[WIDTH-1]) ? -a_r : a_r;
        b_abs = (sgn_r && b_r[WIDTH-1]) ? -b_r : b_r;

        // Shift-add: the product grows into the upper half as the multiplier drains out the bottom.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, b_r};
        div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

        prod_neg = -acc;
        fix_hi   = '0;
        fix_lo   = '0;
        if (op_r && dz_r) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else if (op_r) begin
            fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_res ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
        end else begin
            fix_hi = neg_res ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_res ? prod_neg[WIDTH-1:0]       : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            op_r    <= 1'b0;
            sgn_r   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_r    <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            a_raw   <= '0;
            acc     <= '0;
            done_o  <= 1'b0;
            dz_o    <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !cancel_i) begin
                        op_r  <= op_i;
                        sgn_r <= signed_i;
                        a_r   <= a_i;
                        b_r   <= b_i;
                        a_raw <= a_i;
                    end
                end
                S_PREP: begin
                    neg_res <= sgn_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_rem <= sgn_r && a_r[WIDTH-1];
                    dz_r    <= (b_r == '0);
                    b_r     <= b_abs;
                    acc     <= {{WIDTH{1'b0}}, a_abs};
                    cnt     <= '0;
                end
                S_RUN: begin
                    acc <= op_r ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase

            done_o <= fix_commit;
            dz_o   <= fix_commit && op_r && dz_r;

            if (fix_commit) begin
                hi_o <= fix_hi;
                lo_o <= fix_lo;
            end else begin
                if (hi_we_i) hi_o <= wdata_i;
                if (lo_we_i) lo_o <= wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i, op_i, signed_i, cancel_i, hi_we_i, lo_we_i;
    logic [W-1:0] a_i, b_i, wdata_i;
    logic         busy_o, done_o, dz_o;
    logic [W-1:0] hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .signed_i(signed_i),
        .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic op, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start_i  = 1'b1;
        op_i     = op;
        signed_i = sgn;
        a_i      = a;
        b_i      = b;
    endtask

    // Called at the negedge of cycle 0 after issue(); returns at the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz,
                          input int glitch_start, input int glitch_hiwe, input string name);
        int bad = 0;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            hi_we_i = 1'b0;
            if (busy_o !== 1'b1 || done_o !== 1'b0) bad++;
            if (k == glitch_start) begin
                start_i = 1'b1;
                a_i     = 32'hDEAD_BEEF;
                b_i     = 32'h0000_0003;
            end
            if (k == glitch_hiwe) begin
                hi_we_i = 1'b1;
                wdata_i = 32'h1234_5678;
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        hi_we_i = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s busy_window: %0d bad cycles, required 0", name, bad);
        end
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_cycle: done=%b busy=%b, required done=1 busy=0", name, done_o, busy_o);
        end
        n_checks++;
        if (hi_o !== exp_hi || lo_o !== exp_lo) begin
            n_fail++;
            $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h", name, hi_o, lo_o, exp_hi, exp_lo);
        end
        n_checks++;
        if (dz_o !== exp_dz) begin
            n_fail++;
            $display("FAIL %s dz: got %b, required %b", name, dz_o, exp_dz);
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b0 || dz_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b dz=%b busy=%b, required 0 0 0", name, done_o, dz_o, busy_o);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || dz_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0",
                     busy_o, done_o, dz_o, hi_o, lo_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0, "mul_max");
        idle_check("mul_max");
        issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0, "mul_signed");
        idle_check("mul_signed");
        issue(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
        run_op(32'h0000_0001, 32'h0000_0000, 1'b0, 0, 0, "mul_carry");
        idle_check("mul_carry");
    endtask

    task automatic test_div;
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        run_op(32'd2, 32'd14, 1'b0, 0, 0, "div_unsigned");
        idle_check("div_unsigned");
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0, "div_signed");
        idle_check("div_signed");
        issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(32'h0000_0000, 32'h8000_0000, 1'b0, 0, 0, "div_overflow");
        idle_check("div_overflow");
    endtask

    task automatic test_div_zero;
        issue(1'b1, 1'b0, 32'd5, 32'd0);
        run_op(32'd5, 32'hFFFF_FFFF, 1'b1, 0, 0, "dz_unsigned");
        idle_check("dz_unsigned");
        issue(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0);
        run_op(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0, 0, "dz_signed");
        idle_check("dz_signed");
    endtask

    task automatic test_cancel_reset;
        int seen_done = 0;
        hi_we_i = 1'b1;
        wdata_i = 32'h0000_AAAA;
        @(negedge clk);
        hi_we_i = 1'b0;
        lo_we_i = 1'b1;
        wdata_i = 32'h0000_5555;
        @(negedge clk);
        lo_we_i = 1'b0;
        n_checks++;
        if (hi_o !== 32'h0000_AAAA || lo_o !== 32'h0000_5555) begin
            n_fail++;
            $display("FAIL preload: hi=%h lo=%h, required hi=0000aaaa lo=00005555", hi_o, lo_o);
        end

        issue(1'b1, 1'b0, 32'd100, 32'd7);
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_busy: busy=%b, required 0", busy_o);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL cancel_no_done: %0d done pulses, required 0", seen_done);
        end
        n_checks++;
        if (hi_o !== 32'h0000_AAAA || lo_o !== 32'h0000_5555) begin
            n_fail++;
            $display("FAIL cancel_hilo: hi=%h lo=%h, required hi=0000aaaa lo=00005555", hi_o, lo_o);
        end

        issue(1'b1, 1'b0, 32'd100, 32'd7);
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || dz_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
            n_fail++;
            $display("FAIL midop_reset: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0",
                     busy_o, done_o, dz_o, hi_o, lo_o);
        end
        @(negedge clk);
    endtask

    task automatic test_concurrency;
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        run_op(32'd2, 32'd14, 1'b0, 5, 0, "start_ignored");
        idle_check("start_ignored");
        issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, W + 2, "fix_beats_mthi");
        idle_check("fix_beats_mthi");
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        run_op(32'd2, 32'd14, 1'b0, 0, 0, "b2b_first");
        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0, "b2b_second");
        idle_check("b2b_second");
    endtask

    initial begin
        rst      = 1'b0;
        start_i  = 1'b0;
        op_i     = 1'b0;
        signed_i = 1'b0;
        a_i      = '0;
        b_i      = '0;
        cancel_i = 1'b0;
        hi_we_i  = 1'b0;
        lo_we_i  = 1'b0;
        wdata_i  = '0;
        @(negedge clk);
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_cancel_reset;
        test_concurrency;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
